aes128_enc_top: RTL and testbench
=================================

Name: aes128_enc_top

Overview:
- Iterative AES-128 encryption core (FIPS-197): expands a 128-bit key once on request, then encrypts 128-bit blocks one round per clock.
- Standalone crypto leaf; integrating logic drives init/next commands and polls the enc_ready / ready status flags.

Parameters:
- none (AES-128 only; Nr = 10 fixed)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- init  in  1  key-expansion command; rising edge detected
- next  in  1  encrypt command; rising edge detected
- key  in  128  cipher key; bits [127:120] = key byte 0
- data  in  128  plaintext block; bits [127:120] = state byte 0
- enc_ready  out  1  core idle, able to accept a command
- result  out  128  ciphertext; same byte order as data
- ready  out  1  result holds a valid ciphertext

Behaviour:
- Reset: while reset=0 at a clk edge, FSM goes to IDLE; enc_ready=0, ready=0, result=0, key_valid=0, edge-detect registers=0. Reset mid-operation aborts without side effects.
- Edge detect: init_re = init & ~init_q; next_re = next & ~next_q. init_q/next_q are registered every cycle, including while busy. A level held high (e.g. init tied high) triggers exactly one command.
- enc_ready = 1 only in IDLE, and only one or more cycles after reset release.
- FSM states: IDLE, KEXP, ENC.
- IDLE + init_re -> KEXP:
  - capture key into round key rk[0]; clear key_valid and ready; enc_ready falls the next cycle.
  - KEXP runs 10 cycles, computing rk[i] from rk[i-1] with RotWord, SubWord and Rcon(i).
  - After rk[10], return to IDLE; set key_valid.
  - Init-to-enc_ready latency: 11 cycles after the accepting edge.
- IDLE + next_re + key_valid -> ENC:
  - capture state = data XOR rk[0]; clear ready.
  - ENC runs 10 cycles. Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10 omits MixColumns.
  - On the final cycle, load result and set ready=1; return to IDLE.
  - Next-to-enc_ready latency: 11 cycles. enc_ready is guaranteed low at most 1 cycle after acceptance.
- next_re with key_valid=0: ignored.
- init_re and next_re in the same IDLE cycle: init wins; next is dropped.
- Commands arriving while busy (KEXP or ENC) are ignored; no queuing.
- key and data are sampled only at acceptance; later changes have no effect on a command in progress.
- result and ready are held stable until the next accepted command clears ready. result keeps its last value.
- A new init invalidates the old schedule; a following next must wait for enc_ready.
- GF(2^8) arithmetic uses polynomial 0x11B. S-box is the standard FIPS-197 table, implemented combinationally.

Decomposition:
- Shared package aes_pkg:
  - Nr=10, Rcon table (01,02,04,08,10,20,40,80,1B,36)
  - FSM state enum
  - functions xtime, mix_column, shift_rows
- Sub-module aes_sbox: 8-bit combinational S-box lookup.
- Instances: 16 for the datapath, 4 for SubWord in key expansion.

Test Plan:
- Reset held low for 2 cycles -> enc_ready=0, ready=0, result=0. After release: enc_ready=1 (no key yet).
- init held high, key=2b7e151628aed2a6abf7158809cf4f3c -> enc_ready high 11 cycles after the accepting edge. Then data=6bc1bee22e409f96e93d7e117393172a with a 2-cycle next pulse -> enc_ready low within 1 cycle; when it returns: result=3ad77bb40d7a3660a89ecaf32466ef97, ready=1.
- Same key, data=3243f6a8885a308d313198a2e0370734 -> result=3925841d02dc09fbdc118597196a0b32.
- key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff -> result=69c4e0d86a7b0430d8cdb78070b4c55a. Back-to-back next without re-init -> same result again.
- Zero key, zero data -> result=66e94bd4ef8a2c3b884cfa59ca342b2e. A next pulse before any init is ignored: enc_ready stays 1, ready stays 0.
- Reset asserted mid-ENC -> outputs return to reset values. A following next without init is ignored; key_valid is cleared.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption core.
// Provides the round count, the FSM state type, the key-schedule round
// constants and the byte/column helper functions of the cipher datapath.
// Byte ordering: bits [127:120] hold state byte 0; the state is column-major,
// so byte k sits in row k%4, column k/4.
package aes_pkg;

    localparam int unsigned Nr = 10;

    typedef enum logic [1:0] {
        StIdle,
        StKexp,
        StEnc
    } aes_state_e;

    // Round constant for key-schedule step 1..10; 0 elsewhere.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        unique case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column; bits [31:24] are row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports:
//   in_i  [7:0]  byte to substitute
//   out_o [7:0]  S-box image of in_i
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry 0 occupies the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    always_comb begin
        bit_idx = 11'd2047 - {in_i, 3'b000};
        out_o   = SboxTable[bit_idx -: 8];
    end

endmodule

// File: rtl/aes128_enc_top.sv
// Iterative AES-128 encryption core: one key-schedule step or one cipher
// round per clock. init_i expands key_i into 11 stored round keys; next_i
// encrypts data_i with that schedule.
// Ports:
//   clk_i          clock, all state on the rising edge
//   reset_ni       synchronous active-low reset
//   init_i         key-expansion command (rising edge)
//   next_i         encrypt command (rising edge, needs a valid schedule)
//   key_i  [127:0] cipher key, [127:120] = byte 0
//   data_i [127:0] plaintext, [127:120] = byte 0
//   enc_ready_o    idle and able to accept a command
//   result_o [127:0] ciphertext of the last completed encryption
//   ready_o        result_o holds a valid ciphertext
module aes128_enc_top
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         init_i,
    input  logic         next_i,
    input  logic [127:0] key_i,
    input  logic [127:0] data_i,
    output logic         enc_ready_o,
    output logic [127:0] result_o,
    output logic         ready_o
);

    aes_state_e   fsm_q;
    logic         init_q, next_q;
    logic         key_valid_q;
    logic         enc_ready_q;
    logic         ready_q;
    logic [127:0] result_q;
    logic [127:0] state_q;
    logic [127:0] key_work_q;   // most recently produced round key
    logic [3:0]   round_q;
    logic [127:0] rk_q [0:10];

    logic         init_re, next_re;
    logic [127:0] sub_bytes, shifted, mixed, rk_cur, round_out;
    logic [31:0]  rot_word, sub_word, temp_word;
    logic [127:0] key_next;

    assign init_re = init_i & ~init_q;
    assign next_re = next_i & ~next_q;

    // Cipher datapath S-boxes.
    for (genvar i = 0; i < 16; i++) begin : g_sbox_data
        aes_sbox u_sbox (
            .in_i  (state_q[127 - 8 * i -: 8]),
            .out_o (sub_bytes[127 - 8 * i -: 8])
        );
    end

    // Key-schedule SubWord on RotWord of the last column.
    assign rot_word = {key_work_q[23:0], key_work_q[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sbox_key
        aes_sbox u_sbox (
            .in_i  (rot_word[31 - 8 * i -: 8]),
            .out_o (sub_word[31 - 8 * i -: 8])
        );
    end

    always_comb begin
        temp_word = sub_word ^ {rcon(round_q), 24'h000000};
        key_next[127:96] = key_work_q[127:96] ^ temp_word;
        key_next[95:64]  = key_work_q[95:64] ^ key_next[127:96];
        key_next[63:32]  = key_work_q[63:32] ^ key_next[95:64];
        key_next[31:0]   = key_work_q[31:0] ^ key_next[63:32];
    end

    always_comb begin
        shifted = shift_rows(sub_bytes);
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
        end
        rk_cur = rk_q[0];
        for (int i = 1; i <= 10; i++) begin
            if (round_q == 4'(i)) begin
                rk_cur = rk_q[i];
            end
        end
        // The last round skips MixColumns.
        round_out = (round_q == 4'(Nr)) ? (shifted ^ rk_cur) : (mixed ^ rk_cur);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            fsm_q       <= StIdle;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            key_valid_q <= 1'b0;
            enc_ready_q <= 1'b0;
            ready_q     <= 1'b0;
            result_q    <= '0;
            state_q     <= '0;
            key_work_q  <= '0;
            round_q     <= '0;
        end else begin
            init_q      <= init_i;
            next_q      <= next_i;
            enc_ready_q <= 1'b0;
            unique case (fsm_q)
                StIdle: begin
                    // init has priority; a simultaneous next is dropped.
                    if (init_re) begin
                        rk_q[0]     <= key_i;
                        key_work_q  <= key_i;
                        key_valid_q <= 1'b0;
                        ready_q     <= 1'b0;
                        round_q     <= 4'd1;
                        fsm_q       <= StKexp;
                    end else if (next_re && key_valid_q) begin
                        state_q <= data_i ^ rk_q[0];
                        ready_q <= 1'b0;
                        round_q <= 4'd1;
                        fsm_q   <= StEnc;
                    end else begin
                        enc_ready_q <= 1'b1;
                    end
                end
                StKexp: begin
                    for (int i = 1; i <= 10; i++) begin
                        if (round_q == 4'(i)) begin
                            rk_q[i] <= key_next;
                        end
                    end
                    key_work_q <= key_next;
                    if (round_q == 4'(Nr)) begin
                        key_valid_q <= 1'b1;
                        round_q     <= '0;
                        fsm_q       <= StIdle;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                StEnc: begin
                    state_q <= round_out;
                    if (round_q == 4'(Nr)) begin
                        result_q <= round_out;
                        ready_q  <= 1'b1;
                        round_q  <= '0;
                        fsm_q    <= StIdle;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    assign enc_ready_o = enc_ready_q;
    assign result_o    = result_q;
    assign ready_o     = ready_q;

endmodule

// File: tb/tb_aes128_enc_top.sv
module tb_aes128_enc_top;

    logic         clk;
    logic         reset_n;
    logic         init;
    logic         next;
    logic [127:0] key;
    logic [127:0] data;
    logic         enc_ready;
    logic [127:0] result;
    logic         ready;

    aes128_enc_top dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .init_i      (init),
        .next_i      (next),
        .key_i       (key),
        .data_i      (data),
        .enc_ready_o (enc_ready),
        .result_o    (result),
        .ready_o     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K0 = 128'h0;

    vec_t         vecs [5];
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_pass = 0;
    logic         ready_prev = 1'b0;
    logic [127:0] cur_key;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising edge of ready retires the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (ready && !ready_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ready", 128'(ready), 128'd0);
            end else begin
                check("sb_result", result, exp_q.pop_front());
            end
        end
        ready_prev = ready;
    end

    // Counts ticks until enc_ready, bounded.
    task automatic wait_enc_ready(inout int cyc);
        while (!enc_ready && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_init(input logic [127:0] k);
        int cyc;
        key  = k;
        init = 1'b1;
        tick();
        check("init_accept_busy", 128'(enc_ready), 128'd0);
        init = 1'b0;
        key  = ~k;
        cyc  = 0;
        wait_enc_ready(cyc);
        check("init_latency", 128'(cyc), 128'd11);
        check("init_ready_clear", 128'(ready), 128'd0);
        cur_key = k;
    endtask

    task automatic do_enc(input logic [127:0] d, input logic [127:0] exp);
        int cyc;
        exp_q.push_back(exp);
        data = d;
        next = 1'b1;
        tick();
        check("next_accept_busy", 128'(enc_ready), 128'd0);
        data = ~d;
        tick();
        next = 1'b0;
        cyc  = 1;
        wait_enc_ready(cyc);
        check("enc_latency", 128'(cyc), 128'd11);
        check("enc_ready_flag", 128'(ready), 128'd1);
        check("enc_result", result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        logic stayed;

        vecs[0] = '{K1, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[1] = '{K1, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{K2, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[3] = '{K2, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[4] = '{K0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        reset_n = 1'b0;
        init    = 1'b0;
        next    = 1'b0;
        key     = '0;
        data    = '0;
        cur_key = '0;

        // Reset values.
        tick();
        tick();
        check("rst_enc_ready", 128'(enc_ready), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_result", result, 128'd0);
        reset_n = 1'b1;
        tick();
        check("idle_enc_ready", 128'(enc_ready), 128'd1);

        // next before any key expansion is ignored.
        next = 1'b1;
        tick();
        tick();
        next   = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!enc_ready || ready) stayed = 1'b0;
        end
        check("nokey_next_ignored", 128'(stayed), 128'd1);

        // init held high triggers exactly one expansion.
        key  = K1;
        init = 1'b1;
        tick();
        check("init_hold_accept", 128'(enc_ready), 128'd0);
        key = '0;
        cyc = 0;
        wait_enc_ready(cyc);
        check("init_hold_latency", 128'(cyc), 128'd11);
        repeat (5) tick();
        check("init_hold_once", 128'(enc_ready), 128'd1);
        init    = 1'b0;
        cur_key = K1;

        // Vector table; re-expand only when the key changes.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].key !== cur_key) do_init(vecs[i].key);
            do_enc(vecs[i].data, vecs[i].exp);
        end

        // Commands while encrypting are dropped; schedule stays K0.
        exp_q.push_back(vecs[4].exp);
        data = vecs[4].data;
        next = 1'b1;
        tick();
        next = 1'b0;
        repeat (3) tick();
        key  = K1;
        init = 1'b1;
        tick();
        init = 1'b0;
        next = 1'b1;
        tick();
        next = 1'b0;
        cyc  = 5;
        wait_enc_ready(cyc);
        check("busy_latency", 128'(cyc), 128'd11);
        check("busy_result", result, vecs[4].exp);
        do_enc(vecs[4].data, vecs[4].exp);

        // init and next together: init wins, next dropped.
        key  = K2;
        init = 1'b1;
        next = 1'b1;
        tick();
        init = 1'b0;
        next = 1'b0;
        cyc  = 0;
        wait_enc_ready(cyc);
        check("both_latency", 128'(cyc), 128'd11);
        check("both_no_enc", 128'(ready), 128'd0);
        do_enc(vecs[2].data, vecs[2].exp);

        // Reset mid-encryption aborts and drops the key schedule.
        data = vecs[2].data;
        next = 1'b1;
        tick();
        next = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_enc_ready", 128'(enc_ready), 128'd0);
        check("midrst_ready", 128'(ready), 128'd0);
        check("midrst_result", result, 128'd0);
        reset_n = 1'b1;
        tick();
        check("midrst_idle", 128'(enc_ready), 128'd1);
        next = 1'b1;
        tick();
        next   = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!enc_ready || ready) stayed = 1'b0;
        end
        check("midrst_key_cleared", 128'(stayed), 128'd1);

        check("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
